// File: rtl/sys_defs.sv
// sys_defs: shared types for the retire stage and its ROB interface.
package sys_defs;

    localparam int XLEN  = 32;
    localparam int PRF_W = 6;

    typedef struct packed {
        logic             valid;
        logic [PRF_W-1:0] idx;
    } TAG;

    typedef enum logic [1:0] {BYTE, HALF, WORD, DOUBLE} MEM_SIZE;

    typedef enum logic [1:0] {IDLE, STORE, HALTED} RETIRE_STATE;

    typedef struct packed {
        logic            retire_en;
        TAG              retire_t;
        TAG              retire_t_old;
        logic            halt;
        logic            wr_mem;
        logic [4:0]      dest_reg_idx;
        logic [XLEN-1:0] NPC;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] rs2_value;
        logic            take_branch;
        MEM_SIZE         mem_size;
    } ROB_IR_PACKET;

endpackage

// File: rtl/retire.sv
// retire: commits the ROB head, issuing stores and holding the head until granted.
module retire
    import sys_defs::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  ROB_IR_PACKET     rob_ir_packet,
    output logic             ir_stall,
    output logic             arch_we,
    output logic [4:0]       arch_idx,
    output TAG               arch_tag,
    output logic             free_en,
    output TAG               free_tag,
    output logic             mem_req,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_data,
    output MEM_SIZE          mem_size,
    input  logic             mem_gnt,
    output logic             redirect_en,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             halted,
    output logic [CNT_W-1:0] retire_cnt
);

    RETIRE_STATE state, next_state;
    logic        commit;
    logic        unused_npc;

    assign unused_npc = ^rob_ir_packet.NPC;
    assign mem_req    = state == STORE;
    assign halted     = state == HALTED;

    // The head entry stays on rob_ir_packet while stalled, so a granted store
    // commits using the live packet fields.
    always_comb begin
        next_state = state;
        ir_stall   = 1'b0;
        commit     = 1'b0;
        unique case (state)
            IDLE: begin
                ir_stall   = rob_ir_packet.retire_en & rob_ir_packet.wr_mem;
                commit     = rob_ir_packet.retire_en & ~rob_ir_packet.wr_mem;
                next_state = ir_stall ? STORE : (commit & rob_ir_packet.halt) ? HALTED : IDLE;
            end
            STORE: begin
                ir_stall   = ~mem_gnt;
                commit     = mem_gnt;
                next_state = mem_gnt ? (rob_ir_packet.halt ? HALTED : IDLE) : STORE;
            end
            default: ir_stall = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            mem_addr    <= '0;
            mem_data    <= '0;
            mem_size    <= BYTE;
            arch_we     <= 1'b0;
            arch_idx    <= '0;
            arch_tag    <= '0;
            free_en     <= 1'b0;
            free_tag    <= '0;
            redirect_en <= 1'b0;
            redirect_pc <= '0;
            retire_cnt  <= '0;
        end else begin
            state       <= next_state;
            if (state == IDLE && ir_stall) begin
                mem_addr <= rob_ir_packet.result;
                mem_data <= rob_ir_packet.rs2_value;
                mem_size <= rob_ir_packet.mem_size;
            end
            arch_we     <= commit & rob_ir_packet.retire_t.valid & (rob_ir_packet.dest_reg_idx != 5'd0);
            free_en     <= commit & rob_ir_packet.retire_t_old.valid;
            redirect_en <= commit & rob_ir_packet.take_branch;
            if (commit) begin
                arch_idx    <= rob_ir_packet.dest_reg_idx;
                arch_tag    <= rob_ir_packet.retire_t;
                free_tag    <= rob_ir_packet.retire_t_old;
                redirect_pc <= rob_ir_packet.result;
            end
            retire_cnt  <= retire_cnt + CNT_W'(commit);
        end
    end

endmodule

// File: tb/tb_retire.sv
// tb_retire: directed self-checking bench for the retire stage.
module tb_retire;
    import sys_defs::*;

    logic         clock = 1'b0;
    logic         reset_n;
    ROB_IR_PACKET pkt;
    logic         ir_stall, arch_we, free_en, mem_req, mem_gnt, redirect_en, halted;
    logic [4:0]   arch_idx;
    TAG           arch_tag, free_tag;
    logic [31:0]  mem_addr, mem_data, redirect_pc, retire_cnt;
    MEM_SIZE      mem_size;
    int           total = 0;
    int           fails = 0;

    retire #(.CNT_W(32)) dut (
        .clock(clock), .reset_n(reset_n), .rob_ir_packet(pkt), .ir_stall(ir_stall),
        .arch_we(arch_we), .arch_idx(arch_idx), .arch_tag(arch_tag),
        .free_en(free_en), .free_tag(free_tag), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_size(mem_size), .mem_gnt(mem_gnt),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc), .halted(halted),
        .retire_cnt(retire_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic TAG mk(input logic v, input logic [5:0] i);
        TAG t;
        t.valid = v;
        t.idx   = i;
        return t;
    endfunction

    initial begin
        reset_n = 1'b0;
        pkt     = '0;
        mem_gnt = 1'b0;
        #12;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_arch_we", arch_we, 0);
        chk("rst_free_en", free_en, 0);
        chk("rst_redirect", redirect_en, 0);
        chk("rst_halted", halted, 0);
        chk("rst_cnt", retire_cnt, 0);
        chk("rst_stall", ir_stall, 0);
        reset_n = 1'b1;
        tick();

        // ALU retire
        pkt.retire_en = 1'b1;
        pkt.retire_t = mk(1, 12);
        pkt.retire_t_old = mk(1, 3);
        pkt.dest_reg_idx = 5;
        #1 chk("alu_stall", ir_stall, 0);
        tick();
        pkt = '0;
        chk("alu_arch_we", arch_we, 1);
        chk("alu_arch_idx", arch_idx, 5);
        chk("alu_arch_tag", arch_tag, mk(1, 12));
        chk("alu_free_en", free_en, 1);
        chk("alu_free_tag", free_tag, mk(1, 3));
        chk("alu_cnt", retire_cnt, 1);
        chk("alu_redirect", redirect_en, 0);
        tick();
        chk("alu_we_pulse", arch_we, 0);
        chk("alu_free_pulse", free_en, 0);
        chk("idle_cnt", retire_cnt, 1);

        // taken branch to x0
        pkt.retire_en = 1'b1;
        pkt.take_branch = 1'b1;
        pkt.result = 32'h2040;
        pkt.retire_t = mk(1, 7);
        #1 chk("br_stall", ir_stall, 0);
        tick();
        pkt = '0;
        chk("br_redirect", redirect_en, 1);
        chk("br_pc", redirect_pc, 32'h2040);
        chk("br_arch_we", arch_we, 0);
        chk("br_free_en", free_en, 0);
        chk("br_cnt", retire_cnt, 2);
        tick();
        chk("br_pulse", redirect_en, 0);

        // back-to-back ALU retires
        for (int i = 0; i < 4; i++) begin
            pkt = '0;
            pkt.retire_en = 1'b1;
            pkt.dest_reg_idx = 5'(i + 1);
            pkt.retire_t = mk(1, 6'(20 + i));
            #1 chk("b2b_stall", ir_stall, 0);
            tick();
            chk("b2b_we", arch_we, 1);
            chk("b2b_idx", arch_idx, i + 1);
            chk("b2b_tag", arch_tag, mk(1, 6'(20 + i)));
        end
        pkt = '0;
        chk("b2b_cnt", retire_cnt, 6);
        tick();
        chk("b2b_we_end", arch_we, 0);

        // store with three refused cycles then a grant
        pkt.retire_en = 1'b1;
        pkt.wr_mem = 1'b1;
        pkt.result = 32'h100;
        pkt.rs2_value = 32'hAB;
        pkt.mem_size = WORD;
        pkt.retire_t_old = mk(1, 9);
        #1 chk("st_stall_idle", ir_stall, 1);
        chk("st_req_idle", mem_req, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_req", mem_req, 1);
            chk("st_addr", mem_addr, 32'h100);
            chk("st_data", mem_data, 32'hAB);
            chk("st_size", mem_size, WORD);
            chk("st_stall", ir_stall, 1);
            chk("st_nocommit", arch_we | free_en, 0);
        end
        chk("st_cnt_wait", retire_cnt, 6);
        mem_gnt = 1'b1;
        #1 chk("st_gnt_stall", ir_stall, 0);
        chk("st_gnt_req", mem_req, 1);
        chk("st_gnt_addr", mem_addr, 32'h100);
        tick();
        mem_gnt = 1'b0;
        pkt = '0;
        chk("st_done_req", mem_req, 0);
        chk("st_free_en", free_en, 1);
        chk("st_free_tag", free_tag, mk(1, 9));
        chk("st_arch_we", arch_we, 0);
        chk("st_cnt", retire_cnt, 7);

        // reset two cycles into a store
        pkt.retire_en = 1'b1;
        pkt.wr_mem = 1'b1;
        pkt.result = 32'h200;
        tick();
        tick();
        chk("rs_req_before", mem_req, 1);
        reset_n = 1'b0;
        #1 chk("rs_req_async", mem_req, 0);
        chk("rs_cnt", retire_cnt, 0);
        pkt = '0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("rs_req_after", mem_req, 0);
        pkt.retire_en = 1'b1;
        pkt.dest_reg_idx = 1;
        pkt.retire_t = mk(1, 2);
        #1 chk("rs_idle_stall", ir_stall, 0);
        tick();
        chk("rs_idle_commit", retire_cnt, 1);

        // halt
        pkt = '0;
        pkt.retire_en = 1'b1;
        pkt.halt = 1'b1;
        #1 chk("h_stall_commit", ir_stall, 0);
        tick();
        pkt = '0;
        pkt.retire_en = 1'b1;
        pkt.dest_reg_idx = 3;
        pkt.retire_t = mk(1, 4);
        pkt.retire_t_old = mk(1, 5);
        chk("h_halted", halted, 1);
        chk("h_cnt", retire_cnt, 2);
        for (int i = 0; i < 10; i++) begin
            pkt.wr_mem = 1'(i % 2);
            #1 chk("h_stall", ir_stall, 1);
            tick();
            chk("h_cnt_frozen", retire_cnt, 2);
            chk("h_no_req", mem_req, 0);
            chk("h_no_we", arch_we | free_en, 0);
            chk("h_sticky", halted, 1);
        end

        // store carrying halt: store first, halt on grant
        reset_n = 1'b0;
        pkt = '0;
        tick();
        reset_n = 1'b1;
        chk("sh_unhalt", halted, 0);
        pkt.retire_en = 1'b1;
        pkt.wr_mem = 1'b1;
        pkt.halt = 1'b1;
        pkt.result = 32'h300;
        pkt.rs2_value = 32'h55;
        tick();
        chk("sh_req", mem_req, 1);
        chk("sh_not_halted", halted, 0);
        mem_gnt = 1'b1;
        #1 chk("sh_gnt_stall", ir_stall, 0);
        tick();
        mem_gnt = 1'b0;
        chk("sh_halted", halted, 1);
        chk("sh_cnt", retire_cnt, 1);
        chk("sh_req_off", mem_req, 0);
        tick();
        chk("sh_cnt_frozen", retire_cnt, 1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/retire.md
RETIRE -- requirements
Module: retire

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port clock  input  1  the single clock for all state.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rob_ir_packet  input  ROB_IR_PACKET  ROB head: retire_en, retire_t, retire_t_old, halt, wr_mem, dest_reg_idx, NPC, result, rs2_value, take_branch, mem_size.
REQ-005 SHALL have port ir_stall  output  1  combinational hold; the ROB advances its head only on retire_en && !ir_stall.
REQ-006 SHALL have port arch_we / arch_idx / arch_tag  output  1 / 5 / TAG  registered architectural map update.
REQ-007 SHALL have port free_en / free_tag  output  1 / TAG  registered release of the old physical register to the free list.
REQ-008 SHALL have port mem_req / mem_addr / mem_data / mem_size  output  1 / XLEN / XLEN / MEM_SIZE  store request.
REQ-009 SHALL have port mem_gnt  input  1  store accepted this cycle.
REQ-010 SHALL have port redirect_en / redirect_pc  output  1 / XLEN  registered taken-branch retire notice.
REQ-011 SHALL have port halted  output  1  sticky halt.
REQ-012 SHALL have port retire_cnt  output  CNT_W  count of committed instructions.

Function
REQ-013 SHALL implement FSM states IDLE, STORE, HALTED.
REQ-014 "Commit" SHALL mean the head entry is retired this cycle, i.e. the cycle where retire_en=1 and ir_stall=0.
REQ-015 IDLE, retire_en=0: ir_stall SHALL be 0 and there SHALL be no commit.
REQ-016 IDLE, retire_en=1, wr_mem=0, halt=0: ir_stall SHALL be 0 and the entry SHALL commit in the same cycle.
REQ-017 IDLE, retire_en=1, wr_mem=1: ir_stall SHALL be 1, mem_addr/mem_data/mem_size SHALL be latched from result/rs2_value/mem_size, and the FSM SHALL enter STORE.
REQ-018 STORE: mem_req SHALL be 1 and its payload held stable; ir_stall SHALL equal !mem_gnt; on mem_gnt the store SHALL commit and the FSM SHALL return to IDLE.
REQ-019 IDLE, retire_en=1, halt=1: the entry SHALL commit, the FSM SHALL enter HALTED, and halted SHALL be set next cycle.
REQ-020 HALTED: ir_stall SHALL be 1; no further commit, mem_req, or counter change SHALL occur; the only exit SHALL be reset.
REQ-021 On commit, next cycle: arch_we SHALL equal retire_t.valid && dest_reg_idx!=0, with arch_idx=dest_reg_idx and arch_tag=retire_t.
REQ-022 On commit, next cycle: free_en SHALL equal retire_t_old.valid, with free_tag=retire_t_old.
REQ-023 On commit, next cycle: redirect_en SHALL equal take_branch, with redirect_pc=result.
REQ-024 On commit, retire_cnt SHALL increment by 1 and wrap modulo 2^CNT_W.
REQ-025 arch_we, free_en and redirect_en SHALL be single-cycle pulses and SHALL be 0 in any cycle not following a commit.
REQ-026 Latency SHALL be 0 cycles for non-store commit, at least 1 cycle for a store, and 1 cycle from commit to the registered outputs.
REQ-027 A store with halt=1 SHALL perform the store first, then enter HALTED on the grant cycle.
REQ-028 A store SHALL have no timeout: mem_req SHALL stay asserted until mem_gnt.

Reset
REQ-029 On reset_n=0, asynchronously: FSM SHALL be IDLE; mem_req, arch_we, free_en, redirect_en and halted SHALL be 0; retire_cnt SHALL be 0; all payload registers SHALL be 0.
REQ-030 Reset asserted during STORE SHALL drop mem_req immediately and SHALL NOT commit the pending store.

Structure
REQ-031 The ROB_IR_PACKET mem_size field, the RETIRE_STATE enum, and the TAG and MEM_SIZE types SHALL live in the shared sys_defs package.
REQ-032 The block SHALL be a single module with no sub-modules; the FSM and output registers SHALL be local.

Verification
REQ-033 ALU retire: retire_en=1, t={valid,p12}, t_old={valid,p3}, dest=5 -> ir_stall=0; next cycle arch_we=1, idx=5, tag=p12; free_en=1, tag=p3; retire_cnt=1.
REQ-034 Store retire: wr_mem=1, result=0x100, rs2=0xAB, mem_gnt held low 3 cycles -> ir_stall=1 and mem_req=1 with addr 0x100 and data 0xAB stable for 4 cycles; ir_stall=0 on the grant cycle; retire_cnt +1.
REQ-035 Halt: halt=1 retire -> halted=1 next cycle; ir_stall stays 1; retire_cnt frozen despite retire_en=1 for 10 cycles.
REQ-036 Taken branch with dest=0: take_branch=1, result=0x2040 -> redirect_en=1, pc=0x2040 for exactly one cycle; arch_we=0.
REQ-037 Reset mid-store: reset_n low two cycles into STORE -> mem_req=0 immediately; retire_cnt=0; FSM IDLE after release.
REQ-038 Back-to-back: 4 consecutive ALU retires -> 4 consecutive arch_we pulses; retire_cnt=4; ir_stall never 1.
